proc_handshake_tx: RTL and testbench
====================================

Name: proc_handshake_tx

Overview:
Parametrised processor-side transmitter, successor to the 2-state send/ack processor FSM. Buffers words from the local core in a small FIFO and delivers each one to the peer over a 4-phase req/ack handshake. Adds pause/resume mode control, an ack timeout with retry, and status outputs. Sits between the processor core and the bus/peer FSM.

Parameters:
DATA_W, 16, width of the data word (dado).
DEPTH, 4, FIFO depth in words; power of 2, minimum 2.
TIMEOUT, 15, cycles in REQ without ack before abort; minimum 1.

Ports:
clk  in  1  clock
rst  in  1  reset
wr_en  in  1  push wr_data into the FIFO
wr_data  in  DATA_W  word to queue
full  out  1  FIFO holds DEPTH words
level  out  $clog2(DEPTH+1)  words queued
pause_i  in  1  request pause mode (P)
resume_i  in  1  request resume (R)
dado  out  DATA_W  word presented to the peer
send  out  1  4-phase request
ack  in  1  4-phase acknowledge from the peer
busy  out  1  state is not IDLE or PAUSED
paused  out  1  mode is PAUSED
overflow  out  1  1-cycle pulse: wr_en while full, word dropped
timeout_err  out  1  1-cycle pulse: ack timeout abort
sent_cnt  out  16  completed transfers, wraps at 0xFFFF->0

Behaviour:
- Reset: rst, clk as already decided (synchronous, active-high). All outputs are 0 after reset: dado, send, busy, paused, overflow, timeout_err, sent_cnt, level, full. FIFO empties; state becomes IDLE.
- FIFO write: wr_en && !full stores the word at the clock edge. A full FIFO rejects the write even if a pop occurs in the same cycle; the word is dropped and overflow pulses. A simultaneous push and pop on a non-full FIFO leaves level unchanged.
- FSM states: IDLE, REQ, REL, PAUSED.
- IDLE -> PAUSED if a pause request is pending. Otherwise IDLE -> REQ if the FIFO is non-empty. On entry to REQ, dado loads the FIFO head and send=1.
- REQ: if ack=1, pop the head, go to REL, send=0. If TIMEOUT cycles pass with ack=0, send=0, pulse timeout_err, go to IDLE without popping; the word retries.
- REL: wait for ack=0, then increment sent_cnt and go to IDLE. There is no timeout in REL.
- dado stays stable from REQ entry until the REL exit; it holds its last value in IDLE.
- Pause: a rising pause_i latches a pending flag. The flag takes effect only in IDLE; a transfer in progress always completes first. In PAUSED, writes are still accepted and send stays 0.
- Resume: resume_i in PAUSED returns to IDLE on the next edge and clears the pending flag. If pause_i and resume_i are high together, there is no mode change.
- ack=1 while in IDLE or PAUSED is ignored.
- Latency: wr_en sampled at edge t into an empty FIFO in IDLE gives send=1 after edge t+2. A back-to-back transfer with ack dropping immediately takes 3 cycles per word minimum.
- Timeout counter: $clog2(TIMEOUT+1) bits, cleared on REQ entry.
- rst mid-transfer: send drops to 0 after the next edge and the FIFO contents are lost. The peer must treat this as an abort.

Decomposition:
- Package proc_hs_pkg: state enum (IDLE, REQ, REL, PAUSED) and default constants for DATA_W, DEPTH, TIMEOUT.
- Sub-module proc_tx_fifo: synchronous FIFO with push, pop, head, level, full and empty. It carries the FIFO parameters.
- FSM, mode latch, timeout counter and sent_cnt live in the top module.

Test Plan:
- Reset then idle 10 cycles -> all outputs 0, send never rises.
- Write 0xA5A5; peer acks 2 cycles after send and drops ack 1 cycle after send falls -> send high after edge t+2, dado=0xA5A5 while send=1, sent_cnt=1, level=0.
- Write 5 words 0x0001-0x0005 in consecutive cycles, DEPTH=4, peer never acks -> overflow pulses once on the 5th write, full=1, level=4.
- Peer holds ack=0 -> after 15 cycles in REQ, timeout_err pulses and send=0; on retry dado shows the same word, and sent_cnt stays 0 until a later ack.
- pause_i pulsed during REQ -> the transfer completes, then paused=1 and send stays 0 with 2 words queued; resume_i -> transfers resume in order.
- rst asserted while send=1 and level=3 -> after the next edge send=0, level=0, sent_cnt=0, state IDLE.

Source files
------------

// File: rtl/proc_hs_pkg.sv
// proc_hs_pkg: shared types and default constants for the processor-side
// handshake transmitter (proc_handshake_tx) and its FIFO.
//   state_t          : transmitter FSM states
//   DEF_DATA_W       : default word width
//   DEF_DEPTH        : default FIFO depth (power of 2, >= 2)
//   DEF_TIMEOUT      : default REQ cycles without ack before abort (>= 1)
package proc_hs_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        REL    = 2'd2,
        PAUSED = 2'd3
    } state_t;

    localparam int DEF_DATA_W  = 16;
    localparam int DEF_DEPTH   = 4;
    localparam int DEF_TIMEOUT = 15;

endpackage

// File: rtl/proc_handshake_tx_if.sv
// proc_handshake_tx_if: 4-phase req/ack link between the transmitter and
// its peer.
//   dado : word presented to the peer (transmitter -> peer)
//   send : 4-phase request            (transmitter -> peer)
//   ack  : 4-phase acknowledge        (peer -> transmitter)
// Modports: master (transmitter side), slave (peer side).
interface proc_handshake_tx_if
    import proc_hs_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
);
    logic [DATA_W-1:0] dado;
    logic              send;
    logic              ack;

    modport master (output dado, output send, input ack);
    modport slave  (input dado, input send, output ack);
endinterface

// File: rtl/proc_tx_fifo.sv
// proc_tx_fifo: synchronous first-word-fall-through FIFO.
//   clk, rst : clock, synchronous active-high reset (empties the FIFO)
//   push     : store wr_data at the edge (ignored when full)
//   pop      : drop the head at the edge (ignored when empty)
//   wr_data  : word to store
//   head     : oldest stored word (valid when !empty)
//   level    : number of words stored
//   full     : level == DEPTH
//   empty    : level == 0
module proc_tx_fifo
    import proc_hs_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DATA_W-1:0]          wr_data,
    output logic [DATA_W-1:0]          head,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [LW-1:0]     count;
    logic              do_push;
    logic              do_pop;

    // A full FIFO refuses a push even when a pop happens in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // NOTE: sequential state uses <= so every register updates from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // DEPTH is a power of 2, so the pointers wrap on their own.
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is not reset; the pointers and count alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

    assign head  = mem[rd_ptr];
    assign level = count;
    assign full  = (count == LW'(DEPTH));
    assign empty = (count == '0);
endmodule

// File: rtl/proc_handshake_tx.sv
// proc_handshake_tx: buffers words from the core and sends each one to the
// peer over a 4-phase req/ack handshake, with pause/resume, ack timeout
// with retry, and status outputs.
//   clk, rst      : clock, synchronous active-high reset
//   wr_en/wr_data : push a word into the FIFO
//   full/level    : FIFO status
//   pause_i       : rising edge requests pause (taken in IDLE only)
//   resume_i      : leave PAUSED (ignored while pause_i is also high)
//   peer          : dado/send/ack handshake (master modport)
//   busy          : transfer in progress (REQ or REL)
//   paused        : in PAUSED
//   overflow      : 1-cycle pulse, write dropped because FIFO was full
//   timeout_err   : 1-cycle pulse, REQ aborted after TIMEOUT cycles
//   sent_cnt      : completed transfers, wraps
module proc_handshake_tx
    import proc_hs_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [DATA_W-1:0]          wr_data,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] level,
    input  logic                       pause_i,
    input  logic                       resume_i,
    proc_handshake_tx_if.master        peer,
    output logic                       busy,
    output logic                       paused,
    output logic                       overflow,
    output logic                       timeout_err,
    output logic [15:0]                sent_cnt
);
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t            state, state_nx;
    logic [TW-1:0]     tcnt;
    logic [DATA_W-1:0] head;
    logic              fifo_empty;
    logic              fifo_full;
    logic              pop;
    logic              tmo_hit;
    logic              pause_d;
    logic              pause_rise;
    logic              resume_ok;
    logic              pend;
    logic              ne_q;
    logic [DATA_W-1:0] dado_q;
    logic              overflow_q;
    logic              timeout_q;
    logic [15:0]       sent_q;

    proc_tx_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (wr_en),
        .pop     (pop),
        .wr_data (wr_data),
        .head    (head),
        .level   (level),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign pop        = (state == REQ) && peer.ack;
    assign tmo_hit    = (state == REQ) && !peer.ack && (tcnt == TW'(TIMEOUT - 1));
    // Simultaneous pause and resume is a no-op in both directions.
    assign pause_rise = pause_i && !pause_d && !resume_i;
    assign resume_ok  = resume_i && !pause_i;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // NOTE: state_nx gets a default first so every path assigns it and no latch is inferred.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (pend)      state_nx = PAUSED;
                else if (ne_q) state_nx = REQ;
            end
            REQ: begin
                if (peer.ack)     state_nx = REL;
                else if (tmo_hit) state_nx = IDLE;
            end
            REL: begin
                if (!peer.ack) state_nx = IDLE;
            end
            PAUSED: begin
                if (resume_ok) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt       <= '0;
            pause_d    <= 1'b0;
            pend       <= 1'b0;
            ne_q       <= 1'b0;
            dado_q     <= '0;
            overflow_q <= 1'b0;
            timeout_q  <= 1'b0;
            sent_q     <= '0;
        end else begin
            pause_d    <= pause_i;
            // FIFO occupancy is registered before IDLE acts on it, keeping
            // the FIFO flags off the FSM decision path. This is the extra
            // cycle in write-to-send latency; REL always separates a pop
            // from the next IDLE, so the delayed flag is never stale there.
            ne_q       <= !fifo_empty;
            overflow_q <= wr_en && fifo_full;
            timeout_q  <= tmo_hit;

            if ((state == PAUSED) && resume_ok) pend <= 1'b0;
            else if (pause_rise)                pend <= 1'b1;

            // dado is captured once on REQ entry and held through REL and IDLE.
            if ((state == IDLE) && (state_nx == REQ)) begin
                dado_q <= head;
                tcnt   <= '0;
            end else if ((state == REQ) && !peer.ack) begin
                tcnt <= tcnt + 1'b1;
            end

            if ((state == REL) && !peer.ack) sent_q <= sent_q + 16'd1;
        end
    end

    assign peer.send   = (state == REQ);
    assign peer.dado   = dado_q;
    assign busy        = (state == REQ) || (state == REL);
    assign paused      = (state == PAUSED);
    assign full        = fifo_full;
    assign overflow    = overflow_q;
    assign timeout_err = timeout_q;
    assign sent_cnt    = sent_q;
endmodule

// File: tb/tb_proc_handshake_tx.sv
// tb_proc_handshake_tx: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a transaction-level
// model of the transmitter.
module tb_proc_handshake_tx;
    localparam int DATA_W  = 16;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 15;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              wr_en = 1'b0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              full;
    logic [2:0]        level;
    logic              pause_i = 1'b0;
    logic              resume_i = 1'b0;
    logic              busy;
    logic              paused;
    logic              overflow;
    logic              timeout_err;
    logic [15:0]       sent_cnt;

    proc_handshake_tx_if #(.DATA_W(DATA_W)) bus();

    proc_handshake_tx #(
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .full        (full),
        .level       (level),
        .pause_i     (pause_i),
        .resume_i    (resume_i),
        .peer        (bus),
        .busy        (busy),
        .paused      (paused),
        .overflow    (overflow),
        .timeout_err (timeout_err),
        .sent_cnt    (sent_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- peer ----------------
    // 0: never ack, 1: ack after ack_dly cycles of send, drop after drop_dly
    // cycles of !send, 2: random (including spurious acks while idle).
    int peer_mode = 0;
    int ack_dly = 2;
    int drop_dly = 1;
    int rnd_ack_div = 4;
    int hi_cnt = 0;
    int lo_cnt = 0;

    initial begin
        bus.ack = 1'b0;
        forever begin
            @(negedge clk);
            case (peer_mode)
                1: begin
                    if (!bus.ack) begin
                        if (bus.send) begin
                            hi_cnt++;
                            if (hi_cnt >= ack_dly) begin
                                bus.ack = 1'b1;
                                hi_cnt = 0;
                            end
                        end else hi_cnt = 0;
                    end else begin
                        if (!bus.send) begin
                            lo_cnt++;
                            if (lo_cnt >= drop_dly) begin
                                bus.ack = 1'b0;
                                lo_cnt = 0;
                            end
                        end else lo_cnt = 0;
                    end
                end
                2: begin
                    if (!bus.ack) begin
                        if (bus.send) bus.ack = ($urandom_range(0, rnd_ack_div - 1) == 0);
                        else          bus.ack = ($urandom_range(0, 19) == 0);
                    end else if (!bus.send) begin
                        bus.ack = ($urandom_range(0, 1) == 0);
                    end
                end
                default: bus.ack = 1'b0;
            endcase
        end
    end

    // ---------------- monitor: words offered on each send rise ----------------
    logic [DATA_W-1:0] cap[$];
    logic send_prev = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            if (bus.send === 1'b1 && send_prev === 1'b0) cap.push_back(bus.dado);
            send_prev = bus.send;
        end
    end

    // ---------------- reference model ----------------
    // A word queue plus the transfer phase: offering (send high), releasing
    // (waiting for ack to drop) or holding (paused). A queued word becomes
    // eligible for offering one cycle after it is visible in the queue.
    logic [DATA_W-1:0] m_q[$];
    bit                m_req, m_rel, m_hold, m_pend, m_prev_ne, m_pause_prev;
    int                m_age;
    logic [DATA_W-1:0] m_dado;
    logic [15:0]       m_sent;
    bit                m_ovf, m_tmo;

    task automatic model_step();
        int sz;
        bit was_full;
        bit take;
        if (rst) begin
            m_q.delete();
            m_req = 0; m_rel = 0; m_hold = 0; m_pend = 0;
            m_prev_ne = 0; m_pause_prev = 0; m_age = 0;
            m_dado = '0; m_sent = '0; m_ovf = 0; m_tmo = 0;
            return;
        end
        sz       = m_q.size();
        was_full = (sz == DEPTH);
        take     = 0;
        m_tmo    = 0;
        m_ovf    = wr_en && was_full;
        if (m_req) begin
            if (bus.ack) begin
                take = 1; m_req = 0; m_rel = 1;
            end else if (m_age == TIMEOUT - 1) begin
                m_req = 0; m_tmo = 1;
            end else m_age++;
        end else if (m_rel) begin
            if (!bus.ack) begin
                m_rel = 0; m_sent = m_sent + 16'd1;
            end
        end else if (m_hold) begin
            if (resume_i && !pause_i) begin
                m_hold = 0; m_pend = 0;
            end
        end else begin
            if (m_pend) m_hold = 1;
            else if (m_prev_ne && sz > 0) begin
                m_req = 1; m_age = 0; m_dado = m_q[0];
            end
        end
        if (pause_i && !m_pause_prev && !resume_i) m_pend = 1;
        m_pause_prev = pause_i;
        m_prev_ne    = (sz != 0);
        if (take) void'(m_q.pop_front());
        if (wr_en && !was_full) m_q.push_back(wr_data);
    endtask

    bit cmp_en = 0;
    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            check("send",        32'(bus.send),    32'(m_req));
            check("busy",        32'(busy),        32'(m_req || m_rel));
            check("paused",      32'(paused),      32'(m_hold));
            check("level",       32'(level),       32'(m_q.size()));
            check("full",        32'(full),        32'(m_q.size() == DEPTH));
            check("dado",        32'(bus.dado),    32'(m_dado));
            check("sent_cnt",    32'(sent_cnt),    32'(m_sent));
            check("overflow",    32'(overflow),    32'(m_ovf));
            check("timeout_err", 32'(timeout_err), 32'(m_tmo));
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_reset();
        rst = 1'b1; wr_en = 1'b0; pause_i = 1'b0; resume_i = 1'b0;
        peer_mode = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic write_words(input logic [DATA_W-1:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            wr_en = 1'b1; wr_data = first + DATA_W'(i);
            @(negedge clk);
        end
        wr_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int  run;
        int  ovf_cnt;
        bit  seen;
        bit  rose;

        // Reset, then idle: nothing may move.
        @(posedge clk);
        cmp_en = 1;
        do_reset();
        rose = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.send) rose = 1;
        end
        check("idle_send_never", 32'(rose), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_sent_cnt", 32'(sent_cnt), 32'd0);
        check("rst_dado", 32'(bus.dado), 32'd0);

        // Single word, peer acks after 2 cycles, drops 1 cycle after send falls.
        peer_mode = 1; ack_dly = 2; drop_dly = 1;
        wr_en = 1'b1; wr_data = 16'hA5A5;
        @(negedge clk);             // edge t has sampled the write
        wr_en = 1'b0;
        check("lat_t0_send", 32'(bus.send), 32'd0);
        @(negedge clk);             // after t+1
        check("lat_t1_send", 32'(bus.send), 32'd0);
        @(negedge clk);             // after t+2
        check("lat_t2_send", 32'(bus.send), 32'd1);
        check("lat_t2_dado", 32'(bus.dado), 32'h0000_A5A5);
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (sent_cnt == 16'd1 && !busy) seen = 1;
        end
        check("single_done", 32'(seen), 32'd1);
        check("single_sent_cnt", 32'(sent_cnt), 32'd1);
        check("single_level", 32'(level), 32'd0);

        // Five writes into a depth-4 FIFO with a silent peer.
        do_reset();
        ovf_cnt = 0;
        for (int i = 1; i <= 5; i++) begin
            wr_en = 1'b1; wr_data = DATA_W'(i);
            @(negedge clk);
            if (overflow) ovf_cnt++;
            if (i == 5) check("ovf_on_5th", 32'(overflow), 32'd1);
        end
        wr_en = 1'b0;
        @(negedge clk);
        if (overflow) ovf_cnt++;
        check("ovf_count", 32'(ovf_cnt), 32'd1);
        check("ovf_level", 32'(level), 32'd4);
        check("ovf_full", 32'(full), 32'd1);

        // Timeout with retry of the same word.
        do_reset();
        wr_en = 1'b1; wr_data = 16'h00C3;
        @(negedge clk);
        wr_en = 1'b0;
        run = 0; seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (timeout_err) seen = 1;
            else if (bus.send) run++;
        end
        check("tmo_seen", 32'(seen), 32'd1);
        check("tmo_run_len", 32'(run), 32'd15);
        check("tmo_send_low", 32'(bus.send), 32'd0);
        check("tmo_level", 32'(level), 32'd1);
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (bus.send) seen = 1;
        end
        check("retry_send", 32'(seen), 32'd1);
        check("retry_dado", 32'(bus.dado), 32'h0000_00C3);
        check("retry_sent_cnt", 32'(sent_cnt), 32'd0);
        peer_mode = 1; ack_dly = 1; drop_dly = 1;
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (sent_cnt == 16'd1) seen = 1;
        end
        check("retry_done", 32'(seen), 32'd1);

        // Pause during a transfer, then resume.
        do_reset();
        peer_mode = 1; ack_dly = 3; drop_dly = 1;
        cap.delete();
        write_words(16'h0011, 1);
        write_words(16'h0022, 1);
        write_words(16'h0033, 1);
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (bus.send) seen = 1;
            else @(negedge clk);
        end
        check("pause_req_up", 32'(seen), 32'd1);
        pause_i = 1'b1;
        @(negedge clk);
        pause_i = 1'b0;
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (paused) seen = 1;
        end
        check("pause_entered", 32'(seen), 32'd1);
        check("pause_sent_cnt", 32'(sent_cnt), 32'd1);
        check("pause_level", 32'(level), 32'd2);
        rose = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.send) rose = 1;
        end
        check("pause_send_quiet", 32'(rose), 32'd0);
        check("pause_held", 32'(paused), 32'd1);
        resume_i = 1'b1;
        @(negedge clk);
        resume_i = 1'b0;
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (sent_cnt == 16'd3 && !busy) seen = 1;
        end
        check("resume_done", 32'(seen), 32'd1);
        check("order_count", 32'(cap.size()), 32'd3);
        if (cap.size() == 3) begin
            check("order_0", 32'(cap[0]), 32'h11);
            check("order_1", 32'(cap[1]), 32'h22);
            check("order_2", 32'(cap[2]), 32'h33);
        end

        // Reset in the middle of a transfer with three words queued.
        do_reset();
        write_words(16'h0100, 3);
        check("midrst_pre_send", 32'(bus.send), 32'd1);
        check("midrst_pre_level", 32'(level), 32'd3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_send", 32'(bus.send), 32'd0);
        check("midrst_level", 32'(level), 32'd0);
        check("midrst_sent_cnt", 32'(sent_cnt), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);

        // Randomized traffic: fast peer, then slow peer that often times out.
        for (int phase = 0; phase < 2; phase++) begin
            do_reset();
            peer_mode = 2;
            rnd_ack_div = (phase == 0) ? 3 : 14;
            for (int i = 0; i < 1500; i++) begin
                rst      = ($urandom_range(0, 399) == 0);
                wr_en    = ($urandom_range(0, 9) < 4);
                wr_data  = DATA_W'($urandom);
                pause_i  = ($urandom_range(0, 39) == 0);
                resume_i = ($urandom_range(0, 24) == 0);
                @(negedge clk);
            end
            rst = 1'b0; wr_en = 1'b0; pause_i = 1'b0; resume_i = 1'b0;
            repeat (5) @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
